// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// STATUS register bit layout and register offsets.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;
   localparam int STAT_CNT_W   = 7;

   localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
   localparam logic [31:0] OFS_STATUS = 32'h0000_0004;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO
// is still accepted when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store pushes a byte into the
// FIFO, STATUS reports count/overflow/busy/empty/full.
//
// state   | meaning
// S_IDLE  | line high; pops FIFO head into shifter when non-empty
// S_START | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
   parameter int          CLKS_PER_BIT = 4,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        tx
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t         r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_ovf;

   logic          w_sel_tx;
   logic          w_sel_st;
   logic          w_wr_tx;
   logic          w_wr_st;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_baud_done;
   logic [7:0]    w_fifo_data;
   logic [CW-1:0] w_count;
   logic          w_unused_wdata;

   assign w_sel_tx       = (DataAdr == BASE_ADDR + OFS_TXDATA);
   assign w_sel_st       = (DataAdr == BASE_ADDR + OFS_STATUS);
   assign w_wr_tx        = MemWrite && w_sel_tx;
   assign w_wr_st        = MemWrite && w_sel_st;
   assign w_pop          = (r_state == S_IDLE) && !w_empty;
   assign w_busy         = (r_state != S_IDLE);
   assign w_baud_done    = (r_baud == BAUD_LAST);
   assign w_unused_wdata = ^WriteData[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_wr_tx),
      .i_pop   (w_pop),
      .i_data  (WriteData[7:0]),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // A store that meets a same-edge pop is accepted, so it never overflows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_wr_st && WriteData[3]) begin
         r_ovf <= 1'b0;
      end else if (w_wr_tx && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= w_fifo_data;
                  r_state <= S_START;
                  r_baud  <= '0;
               end
            end
            S_START: begin
               if (w_baud_done) begin
                  r_state <= S_DATA;
                  r_baud  <= '0;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= S_STOP;
                     r_bit_idx <= '0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_done) begin
                  r_state <= S_IDLE;
                  r_baud  <= '0;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_baud  <= '0;
            end
         endcase
      end
   end

   always_comb begin
      case (r_state)
         S_START: tx = 1'b0;
         S_DATA:  tx = r_shift[r_bit_idx];
         default: tx = 1'b1;
      endcase
   end

   always_comb begin
      ReadData = '0;
      if (w_sel_st) begin
         ReadData[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
         ReadData[STAT_OVF]   = r_ovf;
         ReadData[STAT_BUSY]  = w_busy;
         ReadData[STAT_EMPTY] = w_empty;
         ReadData[STAT_FULL]  = w_full;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based frame-timing model checked every cycle,
// a table of register-access vectors, and hand-written frame/overflow/reset sequences.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'h0000_0200;
   localparam logic [31:0] STAT  = 32'h0000_0204;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;
   localparam int          FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = STAT;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        tx;

   int checks = 0;
   int failures = 0;

   // Model: queue of accepted bytes, cycles left in current frame, byte in flight.
   byte unsigned m_q[$];
   bit           m_ovf;
   int           m_rem;
   logic [7:0]   m_cur;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [31:0] rd_adr;
      logic [31:0] exp_rd;
      logic        exp_tx;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_rem = 0;
      m_cur = '0;
   endtask

   task automatic model_update();
      bit wr_tx, wr_st, pop, full;
      if (!reset) begin
         model_reset();
         return;
      end
      wr_tx = MemWrite && (DataAdr == BASE);
      wr_st = MemWrite && (DataAdr == STAT);
      pop   = (m_rem == 0) && (m_q.size() != 0);
      full  = (m_q.size() == DEPTH);
      if (wr_tx && full && !pop) m_ovf = 1'b1;
      if (wr_st && WriteData[3]) m_ovf = 1'b0;
      if (pop) begin
         m_cur = m_q.pop_front();
         m_rem = FRAME;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (wr_tx && (!full || pop)) m_q.push_back(WriteData[7:0]);
   endtask

   function automatic logic model_tx();
      int slot;
      if (m_rem == 0) return 1'b1;
      slot = (FRAME - m_rem) / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return m_cur[slot-1];
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[10:4] = 7'(m_q.size());
      s[3] = m_ovf;
      s[2] = (m_rem != 0);
      s[1] = (m_q.size() == 0);
      s[0] = (m_q.size() == DEPTH);
      return s;
   endfunction

   task automatic model_check();
      chk("tx_vs_model", {31'b0, tx}, {31'b0, model_tx()});
      chk("rdata_vs_model", ReadData, (DataAdr == STAT) ? model_status() : 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      model_check();
   endtask

   task automatic drive(input bit we, input logic [31:0] adr, input logic [31:0] wd);
      MemWrite  = we;
      DataAdr   = adr;
      WriteData = wd;
   endtask

   task automatic idle(input int n);
      drive(1'b0, STAT, 32'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   vec_t vecs[6];
   int   exp_bits[10];

   initial begin
      model_reset();
      #1;
      chk("reset_tx", {31'b0, tx}, 32'h1);
      chk("reset_status", ReadData, 32'h0000_0002);
      idle(2);
      reset = 1'b1;
      idle(2);

      // Register-access vectors from idle: only exact TXDATA/STATUS addresses matter.
      vecs[0] = '{1'b1, 32'h0000_0208, 32'h0000_00FF, BASE,          32'h0,          1'b1};
      vecs[1] = '{1'b1, 32'h0000_01FC, 32'h1234_5678, STAT,          32'h0000_0002, 1'b1};
      vecs[2] = '{1'b1, STAT,          32'h0000_00F7, STAT,          32'h0000_0002, 1'b1};
      vecs[3] = '{1'b0, 32'h0000_0208, 32'h0,         32'h0000_0208, 32'h0,          1'b1};
      vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_00AA, STAT,          32'h0000_0002, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0201, 32'h0000_00AB, STAT,          32'h0000_0002, 1'b1};
      for (int v = 0; v < 6; v++) begin
         drive(vecs[v].we, vecs[v].adr, vecs[v].wd);
         step();
         drive(1'b0, vecs[v].rd_adr, 32'h0);
         #1;
         chk($sformatf("vec%0d_rdata", v), ReadData, vecs[v].exp_rd);
         chk($sformatf("vec%0d_tx", v), {31'b0, tx}, {31'b0, vecs[v].exp_tx});
      end
      idle(3);

      // Single 0x55 frame: start, 1,0,1,0,1,0,1,0, stop.
      exp_bits = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      drive(1'b1, BASE, 32'h0000_0055);
      step();
      chk("frame55_push_edge_tx", {31'b0, tx}, 32'h1);
      drive(1'b0, STAT, 32'h0);
      for (int k = 0; k < FRAME; k++) begin
         step();
         chk($sformatf("frame55_tx_c%0d", k), {31'b0, tx}, exp_bits[k / CPB]);
      end
      step();
      chk("frame55_done_status", ReadData, 32'h0000_0002);

      // Nine back-to-back stores: first pops at once, so no overflow.
      for (int b = 1; b <= 9; b++) begin
         drive(1'b1, BASE, 32'(b));
         step();
      end
      idle(9 * (FRAME + 1) + 10);
      chk("nine_bytes_status", ReadData, 32'h0000_0002);

      // Fill to 7 during a frame, then ten more stores: one fits, nine overflow.
      drive(1'b1, BASE, 32'h0000_00C3);
      step();
      idle(3);
      for (int b = 0; b < 7; b++) begin
         drive(1'b1, BASE, 32'h10 + 32'(b));
         step();
      end
      for (int b = 0; b < 10; b++) begin
         drive(1'b1, BASE, 32'h60 + 32'(b));
         step();
      end
      drive(1'b0, STAT, 32'h0);
      #1;
      chk("ovf_full_status", ReadData, 32'h0000_008D);
      drive(1'b1, STAT, 32'h0000_0008);
      step();
      drive(1'b0, STAT, 32'h0);
      #1;
      chk("ovf_cleared_bit", {31'b0, ReadData[3]}, 32'h0);
      idle(9 * (FRAME + 1) + 10);
      chk("ovf_drain_status", ReadData, 32'h0000_0002);

      // Async reset in the middle of 0xA5's data bits with three bytes queued.
      drive(1'b1, BASE, 32'h0000_00A5);
      step();
      drive(1'b1, BASE, 32'h0000_0011);
      step();
      drive(1'b1, BASE, 32'h0000_0022);
      step();
      drive(1'b1, BASE, 32'h0000_0033);
      step();
      idle(12);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("midframe_reset_tx", {31'b0, tx}, 32'h1);
      chk("midframe_reset_status", ReadData, 32'h0000_0002);
      drive(1'b1, BASE, 32'h0000_0077);
      step();
      step();
      drive(1'b0, STAT, 32'h0);
      reset = 1'b1;
      idle(2 * FRAME);
      chk("after_reset_status", ReadData, 32'h0000_0002);

      // Randomised traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4)       drive(1'b1, BASE, $urandom());
         else if (r == 4) drive(1'b1, STAT, $urandom());
         else if (r == 5) drive(1'b1, BASE + 32'(4 * $urandom_range(2, 5)), $urandom());
         else if (r == 6) drive(1'b0, BASE, 32'h0);
         else             drive(1'b0, STAT, 32'h0);
         step();
      end
      drive(1'b1, STAT, 32'h0000_0008);
      step();
      idle((DEPTH + 1) * (FRAME + 1) + 10);
      chk("random_drain_status", ReadData, 32'h0000_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0200: byte address of TXDATA; STATUS is BASE_ADDR+4.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..64.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-006 MemWrite  input  1  processor store strobe, sampled on rising clk.
REQ-007 DataAdr  input  32  processor data byte address.
REQ-008 WriteData  input  32  processor store data.
REQ-009 ReadData  output  32  register read data, combinational on DataAdr.
REQ-010 tx  output  1  serial line; idle high.

Function
REQ-011 Store with DataAdr==BASE_ADDR and FIFO not full SHALL push WriteData[7:0]; FIFO non-empty from the following cycle.
REQ-012 Store to TXDATA while FIFO full SHALL drop the byte and set sticky overflow flag.
REQ-013 Store to BASE_ADDR+4 with WriteData[3]==1 SHALL clear overflow; other bits ignored.
REQ-014 Stores to any other address SHALL be ignored; no state change.
REQ-015 ReadData at BASE_ADDR+4 SHALL be {count[26:0] in bits 31:5? no -- bits 31:11 zero, bits 10:4 = FIFO count, bit3 overflow, bit2 busy, bit1 empty, bit0 full}.
REQ-016 ReadData SHALL be 32'h0 for DataAdr==BASE_ADDR and all other addresses.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE with FIFO non-empty SHALL pop head into shift register and enter START on the same edge; tx falls the cycle after that edge.
REQ-019 Store edge to empty FIFO with FSM in IDLE SHALL produce tx low exactly 2 rising edges after the store edge (push edge, then pop edge).
REQ-020 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA SHALL drive 8 bits LSB first, CLKS_PER_BIT cycles each, 3-bit bit index, then STOP.
REQ-022 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then IDLE; next byte's START follows after one IDLE cycle if FIFO non-empty.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Push while full and pop on the same edge SHALL accept the push (count unchanged, no overflow).
REQ-025 Push and pop on same edge otherwise SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 Baud counter SHALL be width ceil(log2(CLKS_PER_BIT)) and reload to 0 on every state transition.

Reset
REQ-027 reset=0 SHALL immediately force: FSM IDLE, tx=1, FIFO empty (pointers, count 0), overflow 0, baud counter 0, bit index 0.
REQ-028 reset asserted mid-frame SHALL abort the frame and discard all queued bytes; tx returns high without completing the stop bit.
REQ-029 Stores while reset=0 SHALL be ignored.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, STATUS bit-position constants, and register offset constants (TXDATA 0, STATUS 4).
REQ-031 FIFO SHALL be a separate sub-module sync_fifo (parameterised WIDTH, DEPTH; push, pop, full, empty, count).
REQ-032 Top of mmio_uart_tx SHALL hold address decode, status mux, overflow flag and TX FSM.

Verification
REQ-033 Store 32'h0000_0055 to 0x200, CLKS_PER_BIT=4 -> tx low 2 edges later, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, busy 0 after 40 cycles of frame.
REQ-034 Nine back-to-back stores 0x01..0x09 with FIFO_DEPTH=8 -> bytes 0x01..0x09 all transmitted in order (first pops immediately), overflow stays 0.
REQ-035 Ten stores in ten cycles while a frame is in progress and FIFO at 7 -> status full=1, overflow=1, excess bytes never appear on tx; store 0x8 to 0x204 -> overflow=0.
REQ-036 reset pulsed low mid-DATA of byte 0xA5 with 3 bytes queued -> tx=1 asynchronously, status reads 32'h0000_0002, no further frames.
REQ-037 Store 0xFF to 0x208 and read 0x200 -> no tx activity, ReadData=0; read 0x204 when idle -> 32'h0000_0002.
